counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
Sequence monitor for the free-running up-counter's output bus: it consumes the counter value and checks that each sampled value is the previous sample plus one, modulo 2^WIDTH. It locks onto a valid count sequence and flags any break in it. It sits beside the counter in examples and self-checking benches as synthesizable hardware, so `assert`-style checks can be replaced by on-chip status.

Parameters:
WIDTH, 4, width of the monitored counter value
LOCK_COUNT, 2, consecutive correct increments required to declare lock (>=1)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; forces all state/outputs to reset values immediately
en  input  1  sample strobe; value is examined only in cycles with en=1
value  input  WIDTH  counter output being monitored
clr  input  1  synchronous clear of err_count
locked  output  1  registered; 1 while sequence is verified
error  output  1  registered one-cycle pulse on a sequence break while locked
err_count  output  ERR_W  registered saturating count of error pulses
expected  output  WIDTH  registered next expected value (prev sample + 1, mod 2^WIDTH)

Behaviour:
- Reset (async, any time, incl. mid-lock): state=IDLE, locked=0, error=0, err_count=0, expected=0, match counter=0. Takes effect without a clock edge; released state starts at next rising edge.
- en=0 cycle: no state change, error=0; holds locked/expected/err_count. Gaps in en are not breaks.
- States: IDLE, SEEK, LOCKED.
- IDLE, en=1: capture expected<=value+1; match<=0; ->SEEK.
- SEEK, en=1, value==expected: match<=match+1; if match+1==LOCK_COUNT ->LOCKED (locked=1 from next cycle), else stay. expected<=value+1.
- SEEK, en=1, value!=expected: match<=0, stay SEEK, expected<=value+1; no error pulse (not yet locked).
- LOCKED, en=1, value==expected: stay, expected<=value+1.
- LOCKED, en=1, value!=expected: error=1 for exactly one cycle (next cycle), locked<=0, err_count<=err_count+1 saturating at 2^ERR_W-1, match<=0, expected<=value+1, ->SEEK (resync on the offending value).
- Latency: locked, error and err_count change on the clock edge that samples the deciding value; visible one cycle after the value is presented.
- Arithmetic: value+1 computed in WIDTH bits, wraps (2^WIDTH-1 -> 0 is a correct increment, never an error).
- clr=1: err_count<=0 that edge, overriding a simultaneous increment; error pulse and FSM still behave normally.
- err_count at max: stays at max on further errors; error still pulses.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge -> locked=0, error=0, err_count=0, expected=0 immediately.
- Lock + wrap (WIDTH=4, LOCK_COUNT=2): en=1 feeding 13,14,15,0,1 on consecutive cycles -> locked=1 after 15 is sampled; 15->0 gives no error; expected=2 after 1; err_count=0.
- Break: locked, feed 5,6,9,10,11 -> error=1 for one cycle after 9, err_count=1, locked=0; relocks after 11; expected=12.
- Gaps: locked on 3,4, then en=0 for 3 cycles with value=0, then en=1 value=5 -> no error, stays locked.
- Saturation + clr (ERR_W=2): force 5 breaks -> err_count 1,2,3,3,3 with 5 error pulses; clr asserted in the cycle a sixth break is sampled -> err_count=0, error=1.
- Async reset while LOCKED with err_count=2 -> all outputs 0 at once; after release, first sample re-enters SEEK, no error.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker: locks onto a +1 (mod 2^WIDTH) count sequence and flags breaks while locked
module counter_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  input  logic             clr,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {IDLE, SEEK, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [MW-1:0]    match_q, match_d, match_inc;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d, err_q, err_d, hit;
  assign hit       = value == exp_q;
  assign match_inc = match_q + MW'(1);
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    exp_d    = exp_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (en) begin
      exp_d = value + WIDTH'(1);
      case (state_q)
        IDLE: begin
          match_d = '0;
          state_d = SEEK;
        end
        SEEK: begin
          match_d = hit ? match_inc : '0;
          if (hit && match_inc == MW'(LOCK_COUNT)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
        LOCKED: if (!hit) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = SEEK;
          cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + ERR_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr) cnt_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      match_q  <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end
  assign locked    = locked_q;
  assign error     = err_q;
  assign err_count = cnt_q;
  assign expected  = exp_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: randomized and directed checks of counter_checker against a sequence model
module tb_counter_checker;
  localparam int W = 4, LC = 2, EW = 2;
  logic clk = 0, rst = 0, en = 0, clr = 0;
  logic [W-1:0] value = '0;
  logic locked, error;
  logic [EW-1:0] err_count;
  logic [W-1:0] expected;
  int n_tests = 0, n_fail = 0;
  bit m_have, m_locked, m_err;
  int m_prev, m_streak, m_cnt;
  logic [W-1:0] m_exp;

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .clr(clr),
    .locked(locked), .error(error), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] got();
    return {locked, error, 1'b0, err_count, expected};
  endfunction

  function automatic logic [8:0] want();
    return {m_locked, m_err, 1'b0, EW'(m_cnt), m_exp};
  endfunction

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_err = 0; m_prev = 0; m_streak = 0; m_cnt = 0; m_exp = '0;
  endtask

  // Sequence rules: a sample is good when it is the previous sample plus one (mod 2^W)
  task automatic model(input bit e, input logic [W-1:0] v, input bit c);
    m_err = 0;
    if (e) begin
      if (!m_have) begin
        m_have = 1; m_streak = 0; m_locked = 0;
      end else if (int'(v) == (m_prev + 1) % (1 << W)) begin
        if (!m_locked) begin
          m_streak++;
          if (m_streak == LC) m_locked = 1;
        end
      end else begin
        if (m_locked) begin
          m_err = 1;
          m_cnt = (m_cnt == (1 << EW) - 1) ? m_cnt : m_cnt + 1;
        end
        m_locked = 0; m_streak = 0;
      end
      m_prev = int'(v);
    end
    if (c) m_cnt = 0;
    m_exp = m_have ? W'((m_prev + 1) % (1 << W)) : '0;
  endtask

  task automatic drive(input bit e, input logic [W-1:0] v, input bit c);
    @(negedge clk);
    en = e; value = v; clr = c;
    @(posedge clk);
    #1;
    model(e, v, c);
  endtask

  task automatic test_reset();
    #3 rst = 1;
    #1;
    model_reset();
    n_tests++;
    if (got() !== 9'h0) begin n_fail++; $display("FAIL reset: got %h want 000", got()); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_lock_wrap();
    int seq[5] = '{13, 14, 15, 0, 1};
    foreach (seq[i]) begin
      drive(1, W'(seq[i]), 0);
      n_tests++;
      if (got() !== want()) begin n_fail++; $display("FAIL lock_wrap[%0d]: got %h want %h", i, got(), want()); end
      if (seq[i] == 15) begin
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_15: got %b want 1", locked); end
      end
    end
    n_tests++;
    if ({error, err_count, expected} !== {1'b0, 2'd0, 4'd2}) begin
      n_fail++; $display("FAIL wrap_end: got %b/%0d/%0d want 0/0/2", error, err_count, expected);
    end
  endtask

  task automatic test_break();
    int seq[8] = '{2, 3, 4, 5, 6, 9, 10, 11};
    foreach (seq[i]) begin
      drive(1, W'(seq[i]), 0);
      n_tests++;
      if (got() !== want()) begin n_fail++; $display("FAIL break[%0d]: got %h want %h", i, got(), want()); end
      if (seq[i] == 9) begin
        n_tests++;
        if ({locked, error, err_count} !== {1'b0, 1'b1, 2'd1}) begin
          n_fail++; $display("FAIL break_pulse: got %b%b/%0d want 01/1", locked, error, err_count);
        end
      end
    end
    n_tests++;
    if ({locked, error, expected} !== {1'b1, 1'b0, 4'd12}) begin
      n_fail++; $display("FAIL relock: got %b%b/%0d want 10/12", locked, error, expected);
    end
  endtask

  task automatic test_gaps();
    int seq[3] = '{2, 3, 4};
    @(negedge clk) rst = 1;
    #1;
    model_reset();
    @(negedge clk) rst = 0;
    foreach (seq[i]) drive(1, W'(seq[i]), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      n_tests++;
      if (got() !== want()) begin n_fail++; $display("FAIL gap[%0d]: got %h want %h", i, got(), want()); end
    end
    drive(1, 5, 0);
    n_tests++;
    if ({locked, error, expected} !== {1'b1, 1'b0, 4'd6} || got() !== want()) begin
      n_fail++; $display("FAIL gap_resume: got %h want %h", got(), want());
    end
  endtask

  task automatic test_saturation();
    int sat[5] = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      drive(1, m_exp + W'(5), 0);
      n_tests++;
      if ({error, err_count} !== {1'b1, 2'(sat[k])} || got() !== want()) begin
        n_fail++; $display("FAIL sat[%0d]: got err=%b cnt=%0d want err=1 cnt=%0d", k, error, err_count, sat[k]);
      end
      drive(1, m_exp, 0);
      drive(1, m_exp, 0);
    end
    drive(1, m_exp + W'(7), 1);
    n_tests++;
    if ({error, err_count, locked} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL clr_override: got err=%b cnt=%0d lk=%b want 1/0/0", error, err_count, locked);
    end
  endtask

  task automatic test_async_reset();
    drive(1, m_exp, 0);
    drive(1, m_exp, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1, m_exp + W'(3), 0);
      drive(1, m_exp, 0);
      drive(1, m_exp, 0);
    end
    n_tests++;
    if ({locked, err_count} !== {1'b1, 2'd2} || got() !== want()) begin
      n_fail++; $display("FAIL pre_reset: got %h want %h", got(), want());
    end
    #2 rst = 1;
    #1;
    model_reset();
    n_tests++;
    if (got() !== 9'h0) begin n_fail++; $display("FAIL async_reset: got %h want 000", got()); end
    @(negedge clk) rst = 0;
    drive(1, 9, 0);
    n_tests++;
    if ({locked, error, expected} !== {1'b0, 1'b0, 4'd10} || got() !== want()) begin
      n_fail++; $display("FAIL post_reset: got %h want %h", got(), want());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? W'($urandom) : m_exp;
      drive($urandom_range(0, 4) != 0, v, $urandom_range(0, 19) == 0);
      n_tests++;
      if (got() !== want()) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, got(), want()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_wrap();
    test_break();
    test_gaps();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
